// File: rtl/fetch_warp_scheduler_if.sv
// Fetch request bus between the warp scheduler and the instruction cache.
// The master side (scheduler) drives a held-until-accepted request; the
// slave side (cache) answers with fetchReady_i.
interface fetch_warp_scheduler_if #(
  parameter int unsigned NUM_WARP_LOG = 2,
  parameter int unsigned SIZE_PC      = 32
);
  logic                    fetchValid_o;
  logic [NUM_WARP_LOG-1:0] fetchWarp_o;
  logic [SIZE_PC-1:0]      fetchPC_o;
  logic                    fetchReady_i;

  modport master (
    output fetchValid_o,
    output fetchWarp_o,
    output fetchPC_o,
    input  fetchReady_i
  );

  modport slave (
    input  fetchValid_o,
    input  fetchWarp_o,
    input  fetchPC_o,
    output fetchReady_i
  );
endinterface

// File: rtl/fetch_warp_scheduler.sv
// Fetch-side warp scheduler: owns per-warp PCs, picks the next warp
// round-robin among eligible ones, issues a registered fetch request and
// tracks in-flight fetches so flushed warps can have their returning decode
// killed.
module fetch_warp_scheduler #(
  parameter int unsigned NUM_WARP     = 4,
  parameter int unsigned NUM_WARP_LOG = 2,
  parameter int unsigned SIZE_PC      = 32,
  parameter int unsigned PC_STRIDE    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall_i,
  input  logic                    launchValid_i,
  input  logic [NUM_WARP_LOG-1:0] launchWarp_i,
  input  logic [SIZE_PC-1:0]      launchPC_i,
  input  logic                    warpDoneValid_i,
  input  logic [NUM_WARP_LOG-1:0] warpDone_i,
  input  logic [NUM_WARP-1:0]     instValidVector0_i,
  input  logic [NUM_WARP-1:0]     instValidVector1_i,
  input  logic                    flush_i,
  input  logic [NUM_WARP_LOG-1:0] flushWarp_i,
  input  logic [SIZE_PC-1:0]      flushPC_i,
  input  logic                    decodeDoneValid_i,
  input  logic [NUM_WARP_LOG-1:0] decodeDoneWarp_i,
  fetch_warp_scheduler_if.master  fetchBus,
  output logic [NUM_WARP-1:0]     inFlightVector_o,
  output logic [NUM_WARP-1:0]     activeVector_o,
  output logic                    killDecode_o
);

  logic [NUM_WARP-1:0]     activeQ, activeD;
  logic [NUM_WARP-1:0]     inFlightQ, inFlightD;
  logic [NUM_WARP-1:0]     killQ, killD;
  logic [SIZE_PC-1:0]      pcQ [NUM_WARP];
  logic [SIZE_PC-1:0]      pcD [NUM_WARP];
  logic [NUM_WARP_LOG-1:0] lastWarpQ, lastWarpD;
  logic                    fetchValidQ, fetchValidD;
  logic [NUM_WARP_LOG-1:0] fetchWarpQ, fetchWarpD;
  logic [SIZE_PC-1:0]      fetchPCQ, fetchPCD;

  logic [NUM_WARP-1:0]     eligible;
  logic                    accept;
  logic                    grantFound;
  logic [NUM_WARP_LOG-1:0] grantWarp;
  logic [NUM_WARP_LOG-1:0] cand;

  // A warp may fetch when launched, idle, its buffer slots are empty and it
  // is not being redirected this cycle.
  always_comb begin
    eligible = '0;
    for (int w = 0; w < NUM_WARP; w++) begin
      eligible[w] = activeQ[w] & ~inFlightQ[w] & ~instValidVector0_i[w] &
                    ~instValidVector1_i[w] &
                    ~(flush_i && (flushWarp_i == NUM_WARP_LOG'(w)));
    end
  end

  // Round-robin pick starting just after the last granted warp.
  always_comb begin
    grantFound = 1'b0;
    grantWarp  = '0;
    cand       = '0;
    for (int i = 1; i <= NUM_WARP; i++) begin
      cand = lastWarpQ + NUM_WARP_LOG'(i);
      if (!grantFound && eligible[cand]) begin
        grantFound = 1'b1;
        grantWarp  = cand;
      end
    end
  end

  // Next-state: issue, then launch/done, then decode return, then flush, so
  // flush rules see the post-return in-flight state.
  always_comb begin
    activeD     = activeQ;
    inFlightD   = inFlightQ;
    killD       = killQ;
    pcD         = pcQ;
    lastWarpD   = lastWarpQ;
    fetchValidD = fetchValidQ;
    fetchWarpD  = fetchWarpQ;
    fetchPCD    = fetchPCQ;
    accept      = fetchValidQ & fetchBus.fetchReady_i;

    if (accept) fetchValidD = 1'b0;

    // A new request may only be loaded when the output slot frees up.
    if (grantFound && (!fetchValidQ || accept)) begin
      fetchValidD          = 1'b1;
      fetchWarpD           = grantWarp;
      fetchPCD             = pcQ[grantWarp];
      pcD[grantWarp]       = pcQ[grantWarp] + SIZE_PC'(PC_STRIDE);
      inFlightD[grantWarp] = 1'b1;
      lastWarpD            = grantWarp;
    end

    if (warpDoneValid_i) activeD[warpDone_i] = 1'b0;
    if (launchValid_i) begin
      activeD[launchWarp_i] = 1'b1;
      pcD[launchWarp_i]     = launchPC_i;
    end

    if (decodeDoneValid_i) begin
      inFlightD[decodeDoneWarp_i] = 1'b0;
      killD[decodeDoneWarp_i]     = 1'b0;
    end

    if (flush_i) begin
      pcD[flushWarp_i] = flushPC_i;
      if (inFlightD[flushWarp_i]) begin
        // Still sitting unaccepted in the output slot: retract it silently.
        if (fetchValidQ && (fetchWarpQ == flushWarp_i) && !fetchBus.fetchReady_i) begin
          fetchValidD            = 1'b0;
          inFlightD[flushWarp_i] = 1'b0;
        end else begin
          killD[flushWarp_i] = 1'b1;
        end
      end
    end
  end

  // State registers; stall freezes everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      activeQ     <= '0;
      inFlightQ   <= '0;
      killQ       <= '0;
      lastWarpQ   <= NUM_WARP_LOG'(NUM_WARP - 1);
      fetchValidQ <= 1'b0;
      fetchWarpQ  <= '0;
      fetchPCQ    <= '0;
      for (int w = 0; w < NUM_WARP; w++) pcQ[w] <= '0;
    end else if (!stall_i) begin
      activeQ     <= activeD;
      inFlightQ   <= inFlightD;
      killQ       <= killD;
      lastWarpQ   <= lastWarpD;
      fetchValidQ <= fetchValidD;
      fetchWarpQ  <= fetchWarpD;
      fetchPCQ    <= fetchPCD;
      for (int w = 0; w < NUM_WARP; w++) pcQ[w] <= pcD[w];
    end
  end

  assign fetchBus.fetchValid_o = fetchValidQ;
  assign fetchBus.fetchWarp_o  = fetchWarpQ;
  assign fetchBus.fetchPC_o    = fetchPCQ;
  assign inFlightVector_o      = inFlightQ;
  assign activeVector_o        = activeQ;
  assign killDecode_o          = decodeDoneValid_i & killQ[decodeDoneWarp_i];

endmodule
